// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Divide support is compiled in only when MDU_DIV_EN is defined.
package mdu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mdu_state_t;

  localparam logic [1:0] MDU_MUL  = 2'b00;
  localparam logic [1:0] MDU_MULU = 2'b01;
  localparam logic [1:0] MDU_DIV  = 2'b10;
  localparam logic [1:0] MDU_DIVU = 2'b11;

  localparam logic [5:0] OPC_SPECIAL2 = 6'b01_1100;
  localparam logic [5:0] FUNCT_MUL    = 6'b00_0010;

  function automatic logic is_special2_mul(input logic [5:0] opcode, input logic [5:0] funct);
    return (opcode == OPC_SPECIAL2) && (funct == FUNCT_MUL);
  endfunction

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned bits;
    bits = 0;
    while ((32'd1 << bits) < value) bits++;
    return (bits == 0) ? 1 : bits;
  endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// EX-stage <-> MDU handshake and result bus.
interface mdu_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             flush;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;

  modport master (
    output start, op, op_a, op_b, flush,
    input  stall, busy, done, result_lo, result_hi
  );

  modport slave (
    input  start, op, op_a, op_b, flush,
    output stall, busy, done, result_lo, result_hi
  );
endinterface

// File: rtl/mdu_step.sv
// One combinational BITS_PER_CYCLE slice: shift-add multiply or restoring divide.
// The divide path exists only when MDU_DIV_EN is defined.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             mul_i,
  input  logic [WIDTH-1:0] opnd_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  always_comb begin
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH:0]   sum;
`ifdef MDU_DIV_EN
    logic [WIDTH:0]   rem;
    rem = '0;
`endif
    hi  = hi_i;
    lo  = lo_i;
    sum = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mul_i) begin
        // lo holds the unconsumed multiplier bits; product bits shift in from the top.
        sum      = {1'b0, hi} + (lo[0] ? {1'b0, opnd_i} : '0);
        {hi, lo} = {sum, lo[WIDTH-1:1]};
      end
`ifdef MDU_DIV_EN
      else begin
        rem = {hi, lo[WIDTH-1]};
        lo  = {lo[WIDTH-2:0], 1'b0};
        if (rem >= {1'b0, opnd_i}) begin
          rem   = rem - {1'b0, opnd_i};
          lo[0] = 1'b1;
        end
        hi = rem[WIDTH-1:0];
      end
`endif
    end
    hi_o = hi;
    lo_o = lo;
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative MDU control: FSM, iteration counter, operand/sign capture and sign fix-up.
// With MDU_DIV_EN undefined, divide ops run full length and return zero.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input logic            clk,
  input logic            rst,
  mdu_sequencer_if.slave bus
);

  localparam int unsigned   N    = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned   CW   = clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  mdu_state_t       state_q;
  logic [CW-1:0]    count_q;
  logic [1:0]       op_q;
  logic             sign_a_q, sign_b_q;
  logic [WIDTH-1:0] opnd_q, acc_hi_q, acc_lo_q;
  logic [WIDTH-1:0] res_lo_q, res_hi_q;
  logic [WIDTH-1:0] step_hi, step_lo, fix_lo, fix_hi;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             is_signed, accept;

  assign is_signed = ~bus.op[0];
  assign mag_a     = (is_signed & bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
  assign mag_b     = (is_signed & bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;
  assign accept    = (state_q == IDLE) & bus.start & ~bus.flush;

  assign bus.stall     = ~rst & (accept | ((state_q == RUN) & ~bus.flush));
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE) & ~bus.flush;
  assign bus.result_lo = res_lo_q;
  assign bus.result_hi = res_hi_q;

  mdu_step #(
    .WIDTH         (WIDTH),
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_step (
    .mul_i (~op_q[1]),
    .opnd_i(opnd_q),
    .hi_i  (acc_hi_q),
    .lo_i  (acc_lo_q),
    .hi_o  (step_hi),
    .lo_o  (step_lo)
  );

  always_comb begin
    logic [2*WIDTH-1:0] prod;
    prod = {step_hi, step_lo};
    if (~op_q[0] & (sign_a_q ^ sign_b_q)) prod = -prod;
    fix_lo = prod[WIDTH-1:0];
    fix_hi = prod[2*WIDTH-1:WIDTH];
    if (op_q[1]) begin
`ifdef MDU_DIV_EN
      fix_lo = (~op_q[0] & (sign_a_q ^ sign_b_q)) ? -step_lo : step_lo;
      fix_hi = (~op_q[0] & sign_a_q) ? -step_hi : step_hi;
      // Divide by zero: all-ones quotient; remainder already equals op_a.
      if (opnd_q == '0) fix_lo = '1;
`else
      fix_lo = '0;
      fix_hi = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      opnd_q   <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q  <= RUN;
            count_q  <= '0;
            op_q     <= bus.op;
            sign_a_q <= is_signed & bus.op_a[WIDTH-1];
            sign_b_q <= is_signed & bus.op_b[WIDTH-1];
            acc_hi_q <= '0;
            // Divide iterates the dividend through lo against the divisor.
            opnd_q   <= bus.op[1] ? mag_b : mag_a;
            acc_lo_q <= bus.op[1] ? mag_a : mag_b;
          end
        end
        RUN: begin
          if (bus.flush) begin
            state_q <= IDLE;
          end else begin
            acc_hi_q <= step_hi;
            acc_lo_q <= step_lo;
            count_q  <= count_q + 1'b1;
            if (count_q == LAST) begin
              state_q  <= DONE;
              res_lo_q <= fix_lo;
              res_hi_q <= fix_hi;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: vector table plus flush, reset, back-to-back and
// BITS_PER_CYCLE=4 sequences. Divide expectations follow MDU_DIV_EN.
module tb_mdu_sequencer;
  import mdu_pkg::*;

  localparam int unsigned W = 32;
  localparam int unsigned N = 32;
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam int NV = 10;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  vec_t vecs[NV];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mdu_sequencer_if #(.WIDTH(W)) bus ();
  mdu_sequencer_if #(.WIDTH(W)) bus4 ();

  mdu_sequencer #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut (.clk(clk), .rst(rst), .bus(bus));
  mdu_sequencer #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  always @(negedge clk) begin
    if (!rst) assert (!(bus.busy && bus.start)) else $error("start issued while MDU busy");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx);
    int bad;
    bad = 0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.op    = vecs[idx].op;
    bus.op_a  = vecs[idx].a;
    bus.op_b  = vecs[idx].b;
    for (int c = 0; c <= int'(N); c++) begin
      @(negedge clk);
      if (bus.stall !== 1'b1 || bus.done !== 1'b0) bad++;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    @(negedge clk);
    check($sformatf("v%0d stall window", idx), 64'(bad), 64'd0);
    check($sformatf("v%0d done", idx), 64'(bus.done), 64'd1);
    check($sformatf("v%0d stall at done", idx), 64'(bus.stall), 64'd0);
    check($sformatf("v%0d result_lo", idx), 64'(bus.result_lo), 64'(vecs[idx].lo));
    check($sformatf("v%0d result_hi", idx), 64'(bus.result_hi), 64'(vecs[idx].hi));
    @(posedge clk); #1;
    @(negedge clk);
    check($sformatf("v%0d done one-shot", idx), 64'({bus.done, bus.busy}), 64'd0);
  endtask

  task automatic wait_done(input bit use4, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if ((use4 ? bus4.done : bus.done) === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    int t0, td, dcount;
    logic [31:0] prev_lo, prev_hi;

    vecs[0] = '{MDU_MULU, 32'd7,        32'd6,        32'd42,        32'd0};
    vecs[1] = '{MDU_MUL,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1,  32'hFFFFFFFF};
    vecs[2] = '{MDU_MUL,  32'h80000000, 32'hFFFFFFFF, 32'h80000000,  32'd0};
    vecs[3] = '{MDU_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,  32'hFFFFFFFE};
    vecs[4] = '{MDU_MUL,  32'hFFFFFFF9, 32'hFFFFFFFA, 32'd42,        32'd0};
    vecs[5] = '{MDU_DIV,  32'hFFFFFFF9, 32'd2,
                DIV_EN ? 32'hFFFFFFFD : 32'd0, DIV_EN ? 32'hFFFFFFFF : 32'd0};
    vecs[6] = '{MDU_DIVU, 32'd5,        32'd0,
                DIV_EN ? 32'hFFFFFFFF : 32'd0, DIV_EN ? 32'd5 : 32'd0};
    vecs[7] = '{MDU_DIVU, 32'd100,      32'd7,
                DIV_EN ? 32'd14 : 32'd0,       DIV_EN ? 32'd2 : 32'd0};
    vecs[8] = '{MDU_DIV,  32'd7,        32'hFFFFFFFE,
                DIV_EN ? 32'hFFFFFFFD : 32'd0, DIV_EN ? 32'd1 : 32'd0};
    vecs[9] = '{MDU_MULU, 32'h00012345, 32'h00010000, 32'h23450000,  32'h00000001};

    bus.start = 1'b0; bus.op = '0; bus.op_a = '0; bus.op_b = '0; bus.flush = 1'b0;
    bus4.start = 1'b0; bus4.op = '0; bus4.op_a = '0; bus4.op_b = '0; bus4.flush = 1'b0;

    #1;
    check("reset outputs", {bus.stall, bus.busy, bus.done, 61'd0}, 64'd0);
    check("reset results", {bus.result_hi, bus.result_lo}, 64'd0);
    #11 rst = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(i);
    prev_lo = vecs[NV-1].lo;
    prev_hi = vecs[NV-1].hi;

    // Flush in cycle 10 of a MUL.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = MDU_MUL; bus.op_a = 32'd123; bus.op_b = 32'd456;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(negedge clk);
    check("flush stall drop", 64'(bus.stall), 64'd0);
    check("flush busy before edge", 64'(bus.busy), 64'd1);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush idle", 64'({bus.busy, bus.stall}), 64'd0);
    dcount = 0;
    repeat (40) @(negedge clk) if (bus.done === 1'b1) dcount++;
    check("flush no done", 64'(dcount), 64'd0);
    check("flush results held", {bus.result_hi, bus.result_lo}, {prev_hi, prev_lo});

    // Asynchronous reset mid-RUN, checked between clock edges.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = MDU_MULU; bus.op_a = 32'd5; bus.op_b = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("busy before rst", 64'(bus.busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async rst outputs", {bus.stall, bus.busy, bus.done, 61'd0}, 64'd0);
    check("async rst results", {bus.result_hi, bus.result_lo}, 64'd0);
    #1 rst = 1'b0;
    run_vec(0);

    // Back-to-back: second start in cycle N+2.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = MDU_MULU; bus.op_a = 32'd3; bus.op_b = 32'd4;
    t0 = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(1'b0, 100, td);
    check("b2b first done cycle", 64'(td - t0), 64'(N + 1));
    check("b2b first result", 64'(bus.result_lo), 64'd12);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = MDU_MULU; bus.op_a = 32'd5; bus.op_b = 32'd6;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(1'b0, 100, td);
    check("b2b second done cycle", 64'(td - t0), 64'(2 * N + 3));
    check("b2b second result", 64'(bus.result_lo), 64'd30);

    // BITS_PER_CYCLE=4: done in cycle 9.
    @(posedge clk); #1;
    bus4.start = 1'b1; bus4.op = MDU_MUL; bus4.op_a = 32'hFFFFFFF5; bus4.op_b = 32'd13;
    t0 = cyc;
    @(negedge clk);
    check("bpc4 stall at start", 64'(bus4.stall), 64'd1);
    @(posedge clk); #1;
    bus4.start = 1'b0;
    wait_done(1'b1, 40, td);
    check("bpc4 done cycle", 64'(td - t0), 64'd9);
    check("bpc4 result", {bus4.result_hi, bus4.result_lo}, 64'hFFFFFFFF_FFFFFF71);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
